// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encoding, default port map, source limits.
// Round-robin arbitration is selected by defining IRQ_ROUND_ROBIN_EN (see irq_prio_select).
package irq_pkg;

  localparam int MAX_SRC = 8;
  localparam int IDX_W   = 3;

  localparam logic [15:0] DEF_MASK_PORT = 16'h0010;
  localparam logic [15:0] DEF_VEC_PORT  = 16'h0011;
  localparam logic [15:0] DEF_EOI_PORT  = 16'h0012;
  localparam logic [15:0] DEF_PEND_PORT = 16'h0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_select.sv
// Combinational request picker: fixed priority (bit 0 highest) by default,
// round-robin after the last grant when IRQ_ROUND_ROBIN_EN is defined.
module irq_prio_select
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] i_req,
`ifdef IRQ_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]   i_last,
`endif
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

`ifdef IRQ_ROUND_ROBIN_EN
  int w_dist;
  int w_best;

  // Distance from the slot after i_last; the closest requester wins.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_best  = NUM_SRC;
    w_dist  = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dist = (i + NUM_SRC - int'(i_last) - 1) % NUM_SRC;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/irq_sequencer.sv
// Multi-source interrupt sequencer for the TramelBlaze INTERRUPT line with a port-mapped
// mask/vector/pending/EOI register set. IRQ_ROUND_ROBIN_EN selects round-robin arbitration.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [15:0] MASK_PORT = DEF_MASK_PORT,
  parameter logic [15:0] VEC_PORT  = DEF_VEC_PORT,
  parameter logic [15:0] EOI_PORT  = DEF_EOI_PORT,
  parameter logic [15:0] PEND_PORT = DEF_PEND_PORT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_pulse,
  input  logic [15:0]        port_id,
  input  logic [15:0]        out_port,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic               interrupt_ack,
  output logic               interrupt,
  output logic [15:0]        in_port,
  output logic               busy,
  output state_t             dbg_state
);

  state_t               r_state;
  state_t               w_next_state;
  logic [NUM_SRC-1:0]   r_pending;
  logic [NUM_SRC-1:0]   r_overflow;
  logic [NUM_SRC-1:0]   r_mask;
  logic [IDX_W-1:0]     r_cur_id;
  logic                 w_grant;
  logic                 w_ack;
  logic                 w_eoi;
  logic                 w_mask_wr;
  logic                 w_pend_rd;
  logic                 w_valid;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [NUM_SRC-1:0]   w_clr_vec;
  logic [NUM_SRC-1:0]   w_ovf_set;
  logic                 w_unused;

  assign w_eoi     = write_strobe && (port_id == EOI_PORT);
  assign w_mask_wr = write_strobe && (port_id == MASK_PORT);
  assign w_pend_rd = read_strobe && (port_id == PEND_PORT);
  assign w_unused  = ^out_port[15:NUM_SRC];

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_last <= IDX_W'(NUM_SRC - 1);
    else if (w_grant) r_last <= w_sel_idx;
  end

  irq_prio_select #(.NUM_SRC(NUM_SRC)) u_sel (
    .i_req   (r_pending & r_mask),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_idx   (w_sel_idx)
  );
`else
  irq_prio_select #(.NUM_SRC(NUM_SRC)) u_sel (
    .i_req   (r_pending & r_mask),
    .o_valid (w_valid),
    .o_idx   (w_sel_idx)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Mask is only consulted in IDLE, so masking a source mid-REQ never withdraws it.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      IDLE: if (w_valid) begin
        w_next_state = REQ;
        w_grant      = 1'b1;
      end
      REQ: if (interrupt_ack) begin
        w_next_state = SERVICE;
        w_ack        = 1'b1;
      end
      SERVICE: if (w_eoi) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A new pulse on a bit being cleared by the ack re-arms it without counting as overflow.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_clr_vec[i] = w_ack && (r_cur_id == IDX_W'(i));
    end
    w_ovf_set = src_pulse & r_pending & ~w_clr_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending  <= '0;
      r_overflow <= '0;
      r_mask     <= '1;
      r_cur_id   <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_clr_vec) | src_pulse;
      r_overflow <= (w_pend_rd ? '0 : r_overflow) | w_ovf_set;
      if (w_mask_wr) r_mask   <= out_port[NUM_SRC-1:0];
      if (w_grant)   r_cur_id <= w_sel_idx;
    end
  end

  assign interrupt = (r_state == REQ);
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

  always_comb begin
    in_port = '0;
    if (port_id == VEC_PORT) begin
      in_port = {busy, 11'b0, 1'b0, r_cur_id};
    end else if (port_id == MASK_PORT) begin
      in_port[NUM_SRC-1:0] = r_mask;
    end else if (port_id == PEND_PORT) begin
      in_port[8 +: NUM_SRC] = r_overflow;
      in_port[0 +: NUM_SRC] = r_pending;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: expected register reads go through exp_q,
// interrupt/busy timing is checked inline against the documented latencies.
module tb_irq_sequencer;
  import irq_pkg::*;

  localparam int          N    = 4;
  localparam logic [15:0] P_MASK = 16'h0010;
  localparam logic [15:0] P_VEC  = 16'h0011;
  localparam logic [15:0] P_EOI  = 16'h0012;
  localparam logic [15:0] P_PEND = 16'h0013;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src_pulse;
  logic [15:0]   port_id;
  logic [15:0]   out_port;
  logic          write_strobe;
  logic          read_strobe;
  logic          interrupt_ack;
  logic          interrupt;
  logic [15:0]   in_port;
  logic          busy;
  state_t        dbg_state;

  logic [15:0] exp_q[$];
  logic [15:0] got;
  logic [15:0] exp;
  int          n_vec = 0;
  int          n_err = 0;
  int          waited;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  irq_sequencer #(.NUM_SRC(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .src_pulse     (src_pulse),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .interrupt_ack (interrupt_ack),
    .interrupt     (interrupt),
    .in_port       (in_port),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src_pulse = m;
    tick(1);
    src_pulse = '0;
  endtask

  task automatic wr(input logic [15:0] p, input logic [15:0] d);
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    tick(1);
    write_strobe = 1'b0;
    port_id      = '0;
    out_port     = '0;
  endtask

  task automatic read_port(input logic [15:0] p, input logic rs, output logic [15:0] d);
    port_id     = p;
    read_strobe = rs;
    #1 d = in_port;
    tick(1);
    read_strobe = 1'b0;
    port_id     = '0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
  endtask

  task automatic wait_irq(input int max_cyc, output int w);
    w = 0;
    while (!interrupt && (w < max_cyc)) begin
      tick(1);
      w++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_vec++;
    if (interrupt !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_outputs got int=%b busy=%b st=%0d exp int=0 busy=0 st=0", interrupt, busy, dbg_state);
    end
    exp_q.push_back(16'h000f);
    read_port(P_MASK, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_mask got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000);
    read_port(P_VEC, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_vec got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000);
    read_port(P_PEND, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_pend got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000);
    read_port(16'h0055, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL unmapped_read got=%h exp=%h", got, exp); end
  endtask

  task automatic test_latency();
    pulse(4'b0100);
    n_vec++;
    if (interrupt !== 1'b0) begin n_err++; $display("FAIL latency_early got=%b exp=0", interrupt); end
    tick(1);
    n_vec++;
    if (interrupt !== 1'b1) begin n_err++; $display("FAIL latency_2cyc got=%b exp=1", interrupt); end
    exp_q.push_back(16'h8002);
    read_port(P_VEC, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL latency_vec got=%h exp=%h", got, exp); end
    ack();
    n_vec++;
    if (interrupt !== 1'b0 || busy !== 1'b1 || dbg_state !== SERVICE) begin
      n_err++;
      $display("FAIL latency_ack got int=%b busy=%b st=%0d exp int=0 busy=1 st=2", interrupt, busy, dbg_state);
    end
    exp_q.push_back(16'h0000);
    read_port(P_PEND, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL latency_pend_clr got=%h exp=%h", got, exp); end
    ack();
    n_vec++;
    if (dbg_state !== SERVICE) begin n_err++; $display("FAIL ack_in_service got=%0d exp=2", dbg_state); end
    wr(P_EOI, 16'hffff);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL latency_eoi_busy got=%b exp=0", busy); end
  endtask

  task automatic test_priority();
    logic [15:0] first_vec, second_vec;
`ifdef IRQ_ROUND_ROBIN_EN
    first_vec  = 16'h8003;
    second_vec = 16'h8001;
`else
    first_vec  = 16'h8001;
    second_vec = 16'h8003;
`endif
    pulse(4'b1010);
    wait_irq(4, waited);
    n_vec++;
    if (interrupt !== 1'b1) begin n_err++; $display("FAIL prio_first_timeout got=%b exp=1", interrupt); end
    exp_q.push_back(first_vec);
    read_port(P_VEC, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL prio_first_vec got=%h exp=%h", got, exp); end
    ack();
    tick(3);
    n_vec++;
    if (interrupt !== 1'b0) begin n_err++; $display("FAIL prio_no_rise_before_eoi got=%b exp=0", interrupt); end
    wr(P_EOI, 16'h0000);
    n_vec++;
    if (interrupt !== 1'b0) begin n_err++; $display("FAIL prio_gap got=%b exp=0", interrupt); end
    wait_irq(4, waited);
    n_vec++;
    if (interrupt !== 1'b1 || waited != 1) begin
      n_err++;
      $display("FAIL prio_second_rise got int=%b after=%0d exp int=1 after=1", interrupt, waited);
    end
    exp_q.push_back(second_vec);
    read_port(P_VEC, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL prio_second_vec got=%h exp=%h", got, exp); end
    ack();
    wr(P_EOI, 16'h0000);
  endtask

  task automatic test_mask();
    wr(P_MASK, 16'hfffe);
    wr(16'h0020, 16'h0000);
    exp_q.push_back(16'h000e);
    read_port(P_MASK, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mask_write got=%h exp=%h", got, exp); end
    pulse(4'b0001);
    tick(3);
    n_vec++;
    if (interrupt !== 1'b0) begin n_err++; $display("FAIL mask_blocks got=%b exp=0", interrupt); end
    exp_q.push_back(16'h0001);
    read_port(P_PEND, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mask_pend got=%h exp=%h", got, exp); end
    wr(P_MASK, 16'h000f);
    wait_irq(2, waited);
    n_vec++;
    if (interrupt !== 1'b1) begin n_err++; $display("FAIL mask_unmask_timeout got=%b exp=1", interrupt); end
    exp_q.push_back(16'h8000);
    read_port(P_VEC, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mask_vec got=%h exp=%h", got, exp); end
    wr(P_MASK, 16'h0000);
    n_vec++;
    if (interrupt !== 1'b1) begin n_err++; $display("FAIL mask_in_req_holds got=%b exp=1", interrupt); end
    ack();
    wr(P_MASK, 16'h000f);
    wr(P_EOI, 16'h0000);
  endtask

  task automatic test_overflow();
    pulse(4'b0100);
    pulse(4'b0100);
    exp_q.push_back(16'h0404);
    read_port(P_PEND, 1'b1, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL ovf_pend got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0004);
    read_port(P_PEND, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL ovf_clear_on_read got=%h exp=%h", got, exp); end
    wait_irq(4, waited);
    ack();
    wr(P_EOI, 16'h0000);
  endtask

  task automatic test_set_wins();
    pulse(4'b0010);
    wait_irq(4, waited);
    n_vec++;
    if (interrupt !== 1'b1) begin n_err++; $display("FAIL setwin_timeout got=%b exp=1", interrupt); end
    src_pulse     = 4'b0010;
    interrupt_ack = 1'b1;
    tick(1);
    src_pulse     = '0;
    interrupt_ack = 1'b0;
    exp_q.push_back(16'h0002);
    read_port(P_PEND, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL setwin_pend got=%h exp=%h", got, exp); end
    wr(P_EOI, 16'h0000);
    wait_irq(3, waited);
    n_vec++;
    if (interrupt !== 1'b1) begin n_err++; $display("FAIL setwin_regrant got=%b exp=1", interrupt); end
    exp_q.push_back(16'h8001);
    read_port(P_VEC, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL setwin_vec got=%h exp=%h", got, exp); end
    ack();
    wr(P_EOI, 16'h0000);
    exp_q.push_back(16'h0000);
    read_port(P_PEND, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL setwin_final_pend got=%h exp=%h", got, exp); end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] m;
    m = N'($urandom_range(1, (1 << N) - 1));
    wr(P_MASK, 16'h0003);
    pulse(m | 4'b0001);
    wait_irq(4, waited);
    n_vec++;
    if (interrupt !== 1'b1) begin n_err++; $display("FAIL arst_setup got=%b exp=1", interrupt); end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (interrupt !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL arst_immediate got int=%b busy=%b st=%0d exp int=0 busy=0 st=0", interrupt, busy, dbg_state);
    end
    tick(1);
    reset = 1'b1;
    tick(1);
    exp_q.push_back(16'h000f);
    read_port(P_MASK, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL arst_mask got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000);
    read_port(P_PEND, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL arst_pend got=%h exp=%h", got, exp); end
    exp_q.push_back(16'h0000);
    read_port(P_VEC, 1'b0, got);
    exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL arst_vec got=%h exp=%h", got, exp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset         = 1'b0;
    src_pulse     = '0;
    port_id       = '0;
    out_port      = '0;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    interrupt_ack = 1'b0;
    tick(2);
    test_reset();
    reset = 1'b1;
    tick(1);
    test_latency();
    test_priority();
    test_mask();
    test_overflow();
    test_set_wins();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
